// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient store: word width, tap counts,
// address width and the highest legal read address.
package fir_pkg;

   localparam int COEFF_W   = 16;
   localparam int NUM_TAPS  = 21;
   localparam int HALF_TAPS = 11;
   localparam int ADDR_W    = 5;
   localparam int RD_LIMIT  = 10;

   typedef enum logic [1:0] {
      ACC_IDLE  = 2'd0,
      ACC_WRITE = 2'd1,
      ACC_READ  = 2'd2
   } acc_e;

endpackage

// File: rtl/coeff_bank.sv
// One coefficient bank: DEPTH x COEFF_W register file with a single write
// port and a registered read port that can be forced to zero.
module coeff_bank #(
   parameter int COEFF_W = 16,
   parameter int DEPTH   = 11,
   parameter int AW      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic signed [COEFF_W-1:0] wr_data,
   input  logic                      rd_en,
   input  logic                      rd_clr,
   input  logic [AW-1:0]             rd_addr,
   output logic signed [COEFF_W-1:0] rd_data
);

   logic signed [COEFF_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read stage: clear wins over load; otherwise the last value is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/coeff_sram_bank.sv
// Coefficient store split into two banks: taps 0..HALF_TAPS-1 in bank A,
// the remaining taps in bank B, read pairwise at the same bank offset.
module coeff_sram_bank #(
   parameter int COEFF_W   = fir_pkg::COEFF_W,
   parameter int NUM_TAPS  = fir_pkg::NUM_TAPS,
   parameter int HALF_TAPS = fir_pkg::HALF_TAPS
) (
   input  logic                        iClk,
   input  logic                        iRsn,
   input  logic                        iCsn,
   input  logic                        iWrn,
   input  logic [fir_pkg::ADDR_W-1:0]  iAddr,
   input  logic signed [COEFF_W-1:0]   iWrDt,
   input  logic                        iUpdateFlag,
   output logic signed [COEFF_W-1:0]   oRdDtA,
   output logic signed [COEFF_W-1:0]   oRdDtB,
   output logic                        oRdValid,
   output logic                        oCoeffLoaded,
   output logic                        oAddrErr
);

   import fir_pkg::*;

   localparam int BANK_AW = $clog2(HALF_TAPS);
   localparam logic [ADDR_W-1:0] WR_MAX = ADDR_W'(NUM_TAPS - 1);
   localparam logic [ADDR_W-1:0] RD_MAX = ADDR_W'(RD_LIMIT);
   localparam logic [ADDR_W-1:0] B_BASE = ADDR_W'(HALF_TAPS);
   localparam logic [ADDR_W-1:0] B_LIVE = ADDR_W'(NUM_TAPS - HALF_TAPS);

   acc_e                 acc_p0;
   logic                 wr_ok_p0, wr_a_p0, wr_b_p0;
   logic                 rd_ok_p0, rd_bad_p0, rd_clr_b_p0, err_p0;
   logic [BANK_AW-1:0]   idx_a_p0, idx_b_p0;
   logic [NUM_TAPS-1:0]  mask_set_p0, mask_next_p0;

   logic [NUM_TAPS-1:0]  mask;
   logic                 vld_p1, err_p1, loaded_p1;

   always_comb begin
      acc_p0 = ACC_IDLE;
      if (!iCsn) acc_p0 = iWrn ? ACC_READ : ACC_WRITE;
   end

   // Decode stage: bank select, offset into bank B, range errors.
   always_comb begin
      wr_ok_p0    = (acc_p0 == ACC_WRITE) && (iAddr <= WR_MAX);
      wr_a_p0     = wr_ok_p0 && (iAddr < B_BASE);
      wr_b_p0     = wr_ok_p0 && (iAddr >= B_BASE);
      idx_a_p0    = BANK_AW'(iAddr);
      idx_b_p0    = BANK_AW'(iAddr - B_BASE);
      rd_ok_p0    = (acc_p0 == ACC_READ) && (iAddr <= RD_MAX);
      rd_bad_p0   = (acc_p0 == ACC_READ) && !rd_ok_p0;
      rd_clr_b_p0 = rd_bad_p0 || (rd_ok_p0 && (iAddr >= B_LIVE));
      err_p0      = ((acc_p0 == ACC_WRITE) && !wr_ok_p0) || rd_bad_p0;
   end

   // Update clears first so a same-cycle write still marks its own bit.
   always_comb begin
      mask_set_p0  = wr_ok_p0 ? (NUM_TAPS'(1) << iAddr) : '0;
      mask_next_p0 = (iUpdateFlag ? '0 : mask) | mask_set_p0;
   end

   coeff_bank #(
      .COEFF_W (COEFF_W),
      .DEPTH   (HALF_TAPS),
      .AW      (BANK_AW)
   ) u_bank_a (
      .clk     (iClk),
      .rst_n   (iRsn),
      .wr_en   (wr_a_p0),
      .wr_addr (idx_a_p0),
      .wr_data (iWrDt),
      .rd_en   (rd_ok_p0),
      .rd_clr  (rd_bad_p0),
      .rd_addr (idx_a_p0),
      .rd_data (oRdDtA)
   );

   coeff_bank #(
      .COEFF_W (COEFF_W),
      .DEPTH   (HALF_TAPS),
      .AW      (BANK_AW)
   ) u_bank_b (
      .clk     (iClk),
      .rst_n   (iRsn),
      .wr_en   (wr_b_p0),
      .wr_addr (idx_b_p0),
      .wr_data (iWrDt),
      .rd_en   (rd_ok_p0),
      .rd_clr  (rd_clr_b_p0),
      .rd_addr (idx_a_p0),
      .rd_data (oRdDtB)
   );

   // Status stage: registered alongside the bank read data.
   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         mask      <= '0;
         vld_p1    <= 1'b0;
         err_p1    <= 1'b0;
         loaded_p1 <= 1'b0;
      end else begin
         mask      <= mask_next_p0;
         vld_p1    <= rd_ok_p0;
         err_p1    <= err_p0;
         loaded_p1 <= &mask_next_p0;
      end
   end

   assign oRdValid     = vld_p1;
   assign oAddrErr     = err_p1;
   assign oCoeffLoaded = loaded_p1;

endmodule

// File: tb/tb_coeff_sram_bank.sv
// Directed bench for coeff_sram_bank: load, pairwise readback, range errors,
// update-flag handling, write-then-read forwarding and mid-burst reset.
module tb_coeff_sram_bank;

   logic        iClk = 1'b0;
   logic        iRsn;
   logic        iCsn;
   logic        iWrn;
   logic [4:0]  iAddr;
   logic [15:0] iWrDt;
   logic        iUpdateFlag;
   logic [15:0] oRdDtA;
   logic [15:0] oRdDtB;
   logic        oRdValid;
   logic        oCoeffLoaded;
   logic        oAddrErr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 iClk = ~iClk;

   coeff_sram_bank dut (
      .iClk         (iClk),
      .iRsn         (iRsn),
      .iCsn         (iCsn),
      .iWrn         (iWrn),
      .iAddr        (iAddr),
      .iWrDt        (iWrDt),
      .iUpdateFlag  (iUpdateFlag),
      .oRdDtA       (oRdDtA),
      .oRdDtB       (oRdDtB),
      .oRdValid     (oRdValid),
      .oCoeffLoaded (oCoeffLoaded),
      .oAddrErr     (oAddrErr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      iCsn        = 1'b1;
      iWrn        = 1'b1;
      iUpdateFlag = 1'b0;
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      iCsn  = 1'b0;
      iWrn  = 1'b0;
      iAddr = a;
      iWrDt = d;
      step();
      idle();
   endtask

   task automatic rd(input logic [4:0] a);
      iCsn  = 1'b0;
      iWrn  = 1'b1;
      iAddr = a;
      step();
   endtask

   initial begin
      iRsn  = 1'b0;
      iAddr = '0;
      iWrDt = '0;
      idle();
      #3;
      check("rst_a",      oRdDtA,       0);
      check("rst_b",      oRdDtB,       0);
      check("rst_valid",  oRdValid,     0);
      check("rst_loaded", oCoeffLoaded, 0);
      check("rst_err",    oAddrErr,     0);
      @(negedge iClk);
      iRsn = 1'b1;

      // Load 1..21 into addresses 0..20
      for (int i = 0; i <= 20; i++) begin
         wr(5'(i), 16'(i + 1));
         check($sformatf("load_loaded_%0d", i), oCoeffLoaded, (i == 20) ? 1 : 0);
         check($sformatf("load_err_%0d", i), oAddrErr, 0);
      end

      // Back-to-back pairwise reads
      for (int i = 0; i <= 10; i++) begin
         rd(5'(i));
         check($sformatf("rd_a_%0d", i), oRdDtA, 32'(i + 1));
         check($sformatf("rd_b_%0d", i), oRdDtB, (i < 10) ? 32'(i + 12) : 0);
         check($sformatf("rd_vld_%0d", i), oRdValid, 1);
      end
      idle();
      step();
      check("idle_vld",    oRdValid, 0);
      check("idle_hold_a", oRdDtA,   11);
      check("idle_hold_b", oRdDtB,   0);

      // Out-of-range write and read
      wr(5'd25, 16'h7FFF);
      check("wr25_err",    oAddrErr,     1);
      check("wr25_loaded", oCoeffLoaded, 1);
      step();
      check("wr25_err_clr", oAddrErr, 0);
      rd(5'd3);
      check("after25_a", oRdDtA, 4);
      check("after25_b", oRdDtB, 15);
      rd(5'd12);
      check("rd12_err", oAddrErr, 1);
      check("rd12_vld", oRdValid, 0);
      check("rd12_a",   oRdDtA,   0);
      check("rd12_b",   oRdDtB,   0);
      idle();
      step();
      check("rd12_err_clr", oAddrErr, 0);

      // Update flag together with a write: only bit 3 survives
      iUpdateFlag = 1'b1;
      wr(5'd3, 16'hFFFF);
      check("upd_loaded", oCoeffLoaded, 0);
      rd(5'd3);
      check("upd_rd_a",   oRdDtA,   32'h0000_FFFF);
      check("upd_rd_b",   oRdDtB,   15);
      check("upd_rd_vld", oRdValid, 1);
      idle();
      for (int i = 0; i <= 20; i++) begin
         if (i != 3) begin
            wr(5'(i), 16'(i + 1));
            check($sformatf("reload_loaded_%0d", i), oCoeffLoaded, (i == 20) ? 1 : 0);
         end
      end
      wr(5'd3, 16'h0004);
      check("rewrite_loaded", oCoeffLoaded, 1);

      // Read immediately after write
      wr(5'd5, 16'h1234);
      rd(5'd5);
      check("raw_a",   oRdDtA,   32'h1234);
      check("raw_b",   oRdDtB,   17);
      check("raw_vld", oRdValid, 1);

      // Reset in the middle of a read burst
      rd(5'd3);
      check("burst_a", oRdDtA, 4);
      iAddr = 5'd4;
      #2;
      iRsn = 1'b0;
      #1;
      check("mid_rst_a",      oRdDtA,       0);
      check("mid_rst_b",      oRdDtB,       0);
      check("mid_rst_vld",    oRdValid,     0);
      check("mid_rst_loaded", oCoeffLoaded, 0);
      @(posedge iClk);
      idle();
      @(negedge iClk);
      iRsn = 1'b1;
      step();
      check("post_rst_vld", oRdValid, 0);
      rd(5'd0);
      check("post_rst_a",   oRdDtA,   0);
      check("post_rst_b",   oRdDtB,   0);
      check("post_rst_vld1", oRdValid, 1);
      rd(5'd4);
      check("post_rst_a4",  oRdDtA,   0);
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/coeff_sram_bank.md
COEFF_SRAM_BANK -- requirements
Module: coeff_sram_bank

Interface
REQ-001 Parameter COEFF_W, default 16, width of one signed coefficient word.
REQ-002 Parameter NUM_TAPS, default 21, total coefficients stored.
REQ-003 Parameter HALF_TAPS, default 11, depth of each bank (ceil(NUM_TAPS/2)).
REQ-004 iClk  input  1  single block clock, all state on rising edge.
REQ-005 iRsn  input  1  reset, asynchronous, active-low.
REQ-006 iCsn  input  1  chip select from control FSM, active-low.
REQ-007 iWrn  input  1  0 = write, 1 = read; sampled only when iCsn=0.
REQ-008 iAddr  input  5  coefficient address: 0..20 on write, 0..10 on read.
REQ-009 iWrDt  input  COEFF_W  coefficient write data, signed.
REQ-010 iUpdateFlag  input  1  coefficient-update request; clears load tracking.
REQ-011 oRdDtA  output  COEFF_W  bank A read data (taps 0..10), registered.
REQ-012 oRdDtB  output  COEFF_W  bank B read data (taps 11..20), registered.
REQ-013 oRdValid  output  1  high exactly one cycle after each accepted read.
REQ-014 oCoeffLoaded  output  1  high while all NUM_TAPS addresses written since last clear.
REQ-015 oAddrErr  output  1  one-cycle pulse, cycle after an out-of-range access.

Function
REQ-016 Write (iCsn=0, iWrn=0, iAddr<=10) SHALL store iWrDt in bank A[iAddr] at the clock edge.
REQ-017 Write with 11<=iAddr<=20 SHALL store iWrDt in bank B[iAddr-11].
REQ-018 Write with iAddr>20 SHALL change no storage and SHALL assert oAddrErr next cycle.
REQ-019 Read (iCsn=0, iWrn=1, iAddr<=10) SHALL, one cycle later, drive oRdDtA=A[iAddr], oRdDtB=B[iAddr], oRdValid=1.
REQ-020 Read at iAddr=10 SHALL drive oRdDtB=0 (odd tap count; B has 10 live entries).
REQ-021 Read with iAddr>10 SHALL drive oRdValid=0, oRdDtA/oRdDtB=0, oAddrErr=1 next cycle.
REQ-022 iCsn=1 SHALL perform no access; oRdValid=0 next cycle; oRdDtA/oRdDtB hold last values.
REQ-023 Back-to-back reads on consecutive cycles SHALL return one result per cycle, fully pipelined (11 reads -> 11 valid cycles).
REQ-024 Read of an address written in the preceding cycle SHALL return the new data.
REQ-025 A 21-bit written-mask SHALL set bit iAddr on every in-range write.
REQ-026 iUpdateFlag=1 SHALL clear the mask; if a write occurs the same cycle, the clear applies first and that write's bit is set.
REQ-027 oCoeffLoaded SHALL be registered, equal to AND of the mask, asserted the cycle after the 21st distinct address is written.
REQ-028 Re-writing an already-written address SHALL update data and leave oCoeffLoaded unchanged.
REQ-029 iUpdateFlag SHALL NOT clear coefficient storage; reads remain permitted while oCoeffLoaded=0.

Reset
REQ-030 iRsn=0 SHALL asynchronously clear both banks, the mask, and all outputs to 0.
REQ-031 Reset asserted mid-write or mid-read burst SHALL abort the access; no partial update; oRdValid=0 until the next read after release.
REQ-032 First access SHALL be accepted on the first rising edge after iRsn deasserts.

Structure
REQ-033 COEFF_W, NUM_TAPS, HALF_TAPS, address width 5 and read limit 10 SHALL live in shared package fir_pkg.
REQ-034 One sub-module coeff_bank (HALF_TAPS x COEFF_W register file, single write port, registered read port) SHALL be instanced twice (A, B).
REQ-035 Bank-select, address-offset, error, and mask logic SHALL reside in coeff_sram_bank.

Verification
REQ-036 Write 0x0001..0x0015 to addr 0..20, then read 0..10 back-to-back -> (A,B) = (1,12),(2,13)..(10,21),(11,0), oRdValid high 11 cycles, oCoeffLoaded=1 after the 21st write.
REQ-037 Write addr 25 data 0x7FFF -> oAddrErr pulse one cycle, storage unchanged; read addr 12 -> oAddrErr, oRdValid=0, data 0.
REQ-038 Loaded state, iUpdateFlag=1 together with write addr 3 = 0xFFFF -> mask has only bit 3; oCoeffLoaded=0; read addr 3 -> A=0xFFFF.
REQ-039 Write addr 5 = 0x1234, next cycle read addr 5 -> oRdDtA=0x1234 one cycle later.
REQ-040 Assert iRsn=0 mid read burst at addr 4 -> outputs 0 immediately, read addr 0 after release -> A=0, B=0.
